dmem_mmio_responder: RTL and testbench

- Responder on the single-cycle core's data-memory port (addr, wdata, we, re, rdata), replacing the plain data memory.
- Decodes each access to one of three regions: word-addressed RAM, a memory-mapped transmit FIFO that drains to an external valid/ready stream, and status/cycle-counter registers.
- Reads are combinational so the core's single-cycle timing is kept. All state updates on the rising clock edge.

---
 rtl/dmem_mmio_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle core: word RAM, a memory-mapped
// transmit FIFO drained over valid/ready, and status / cycle-counter registers.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int               RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [16:0]      RAM_LIMIT = 17'(2 * RAM_WORDS);
    localparam logic [14:0]      IO_W      = IO_BASE[15:1];

    if (RAM_LIMIT > {1'b0, IO_BASE}) begin : g_ram_overlap
        $error("RAM range reaches IO_BASE; RAM decode shadows the I/O registers");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two between 2 and 16");
    end

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_TXD,
        RGN_STAT,
        RGN_CYC,
        RGN_NONE
    } region_e;

    logic [14:0]       word;
    logic [RAM_AW-1:0] ram_idx;
    region_e           region;

    logic [15:0]      mem_q [RAM_WORDS];
    logic [15:0]      buf_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             badaddr_q, badaddr_d;
    logic [15:0]      cyc_q, cyc_d;

    logic        full, empty, pop, push_req, push_ok;
    logic [3:0]  count4;
    logic [15:0] stat_word;

    assign word    = addr[15:1];
    assign ram_idx = word[RAM_AW-1:0];

    // RAM is checked first so an overlapping RAM range shadows the I/O block.
    always_comb begin
        region = RGN_NONE;
        if ({1'b0, addr} < RAM_LIMIT) begin
            region = RGN_RAM;
        end else if (word == IO_W) begin
            region = RGN_TXD;
        end else if (word == IO_W + 15'd1) begin
            region = RGN_STAT;
        end else if (word == IO_W + 15'd2) begin
            region = RGN_CYC;
        end
    end

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = buf_q[rd_ptr_q];
    assign pop      = tx_valid & tx_ready;
    assign push_req = we & (region == RGN_TXD);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push_ok  = push_req & (!full | pop);

    assign count4    = 4'(count_q);
    assign stat_word = {8'b0, count4, badaddr_q, overflow_q, empty, full};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rdata = '0;
        if (re) begin
            case (region)
                RGN_RAM:  rdata = mem_q[ram_idx];
                RGN_STAT: rdata = stat_word;
                RGN_CYC:  rdata = cyc_q;
                default:  rdata = '0;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky flags: a set on the same edge as a write-1-to-clear wins.
    always_comb begin
        overflow_d = overflow_q;
        badaddr_d  = badaddr_q;
        if (we && region == RGN_STAT) begin
            if (wdata[2]) overflow_d = 1'b0;
            if (wdata[3]) badaddr_d  = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (region == RGN_NONE && (we || re)) begin
            badaddr_d = 1'b1;
        end
    end

    always_comb begin
        cyc_d = cyc_q + 16'd1;
        if (we && region == RGN_CYC) begin
            cyc_d = wdata;
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            badaddr_q  <= 1'b0;
            cyc_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            badaddr_q  <= badaddr_d;
            cyc_q      <= cyc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (push_ok) begin
            buf_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory and survives rst.
    always_ff @(posedge clk) begin
        if (we && region == RGN_RAM) begin
            mem_q[ram_idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: directed scenarios plus
// randomized traffic compared against a queue-based behavioural model.
module tb_dmem_mmio_responder;

    localparam int          RAM_WORDS = 256;
    localparam int          DEPTH     = 4;
    localparam logic [15:0] IO        = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] rdata;
    logic [15:0] tx_data;
    logic        tx_valid;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [15:0] m_mem   [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [15:0] m_q [$];
    bit          m_ovf;
    bit          m_bad;
    logic [15:0] m_cyc;

    dmem_mmio_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(DEPTH),
        .IO_BASE   (IO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // 0 RAM, 1 TXD, 2 STAT, 3 CYC, 4 unmapped
    function automatic int rgn(input logic [15:0] a);
        int wi, io_wi;
        wi    = int'(a) / 2;
        io_wi = int'(IO) / 2;
        if (int'(a) < 2 * RAM_WORDS) return 0;
        if (wi == io_wi)     return 1;
        if (wi == io_wi + 1) return 2;
        if (wi == io_wi + 2) return 3;
        return 4;
    endfunction

    function automatic logic [15:0] exp_stat();
        int n;
        n = m_q.size();
        return {8'h00, 4'(n), m_bad, m_ovf, (n == 0), (n == DEPTH)};
    endfunction

    function automatic logic [15:0] exp_rdata();
        if (!re) return 16'h0000;
        case (rgn(addr))
            0:       return m_mem[int'(addr) / 2];
            2:       return exp_stat();
            3:       return m_cyc;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit rdata_known();
        if (re && rgn(addr) == 0) return m_known[int'(addr) / 2];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_bad = 1'b0;
        m_cyc = 16'h0000;
    endtask

    task automatic apply(input logic w, input logic r, input logic [15:0] a,
                         input logic [15:0] d, input logic rdy);
        we = w; re = r; addr = a; wdata = d; tx_ready = rdy;
        #2;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit pop, push_req, push_ok, ovf_set, bad_set;
        int r;
        @(posedge clk);
        r        = rgn(addr);
        pop      = (m_q.size() > 0) && tx_ready;
        push_req = we && (r == 1);
        push_ok  = push_req && ((m_q.size() < DEPTH) || pop);
        ovf_set  = push_req && !push_ok;
        bad_set  = (r == 4) && (we || re);
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(wdata);
        if (we && r == 2 && wdata[2]) m_ovf = 1'b0;
        if (we && r == 2 && wdata[3]) m_bad = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
        if (bad_set) m_bad = 1'b1;
        m_cyc = (we && r == 3) ? wdata : m_cyc + 16'd1;
        if (we && r == 0) begin
            m_mem[int'(addr) / 2]   = wdata;
            m_known[int'(addr) / 2] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        vectors++;
        if (tx_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_tx_data: got %h expected 0000", tx_data);
        end
        #2 rst = 1'b0;
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h0002 || rdata !== exp_rdata()) begin
            miscompares++;
            $display("FAIL reset_stat: got %h expected 0002", rdata);
        end
        apply(0, 1, IO + 16'd4, 0, 0);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_cyc: got %h expected 0000", rdata);
        end
        tick();
    endtask

    task automatic test_ram();
        apply(1, 0, 16'h0010, 16'hBEEF, 0);
        tick();
        apply(0, 1, 16'h0010, 0, 0);
        vectors++;
        if (rdata !== 16'hBEEF || rdata !== exp_rdata()) begin
            miscompares++;
            $display("FAIL ram_load: got %h expected beef", rdata);
        end
        apply(0, 0, 16'h0010, 0, 0);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL ram_re_low: got %h expected 0000", rdata);
        end
        apply(0, 1, 16'h0011, 0, 0);
        vectors++;
        if (rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ram_odd_addr: got %h expected beef", rdata);
        end
        // Load and store on the same word return the old contents.
        apply(1, 1, 16'h0010, 16'h1234, 0);
        vectors++;
        if (rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ram_rd_wr_same: got %h expected beef", rdata);
        end
        tick();
        apply(1, 0, 16'h0010, 16'hBEEF, 0);
        tick();
    endtask

    task automatic test_fifo_overflow();
        for (int v = 1; v <= 5; v++) begin
            apply(1, 0, IO, 16'(v), 0);
            tick();
        end
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h0045 || rdata !== exp_rdata()) begin
            miscompares++;
            $display("FAIL ovf_stat: got %h expected 0045", rdata);
        end
        for (int i = 1; i <= 4; i++) begin
            apply(0, 0, 0, 0, 1);
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
                miscompares++;
                $display("FAIL ovf_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, tx_valid, tx_data, 16'(i));
            end
            tick();
        end
        apply(0, 1, IO + 16'd2, 0, 1);
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_drained_valid: got %b expected 0", tx_valid);
        end
        vectors++;
        if (rdata !== 16'h0006) begin
            miscompares++;
            $display("FAIL ovf_drained_stat: got %h expected 0006", rdata);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0011; exp_seq[1] = 16'h0012;
        exp_seq[2] = 16'h0013; exp_seq[3] = 16'h00AA;
        apply(1, 0, IO + 16'd2, 16'h0004, 0);
        tick();
        for (int v = 0; v < 4; v++) begin
            apply(1, 0, IO, 16'h0010 + 16'(v), 0);
            tick();
        end
        apply(1, 0, IO, 16'h00AA, 1);
        vectors++;
        if (tx_data !== 16'h0010) begin
            miscompares++;
            $display("FAIL fpp_head: got %h expected 0010", tx_data);
        end
        tick();
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h0041 || rdata !== exp_rdata()) begin
            miscompares++;
            $display("FAIL fpp_stat: got %h expected 0041", rdata);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 1);
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL fpp_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, tx_valid, tx_data, exp_seq[i]);
            end
            tick();
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fpp_empty: got %b expected 0", tx_valid);
        end
    endtask

    task automatic test_cycle();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000;
        apply(1, 0, IO + 16'd4, 16'hFFFE, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, IO + 16'd4, 0, 0);
            vectors++;
            if (rdata !== exp_seq[i] || rdata !== exp_rdata()) begin
                miscompares++;
                $display("FAIL cyc_%0d: got %h expected %h", i, rdata, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_badaddr();
        apply(0, 1, 16'h8000, 0, 0);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL bad_rdata: got %h expected 0000", rdata);
        end
        tick();
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h000A || rdata !== exp_rdata()) begin
            miscompares++;
            $display("FAIL bad_set: got %h expected 000a", rdata);
        end
        tick();
        apply(1, 0, IO + 16'd2, 16'h0008, 0);
        tick();
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h0002) begin
            miscompares++;
            $display("FAIL bad_clear: got %h expected 0002", rdata);
        end
        tick();
        // Unmapped store carrying the clear bit still sets the flag.
        apply(1, 0, 16'h9000, 16'h0008, 0);
        tick();
        apply(0, 1, IO + 16'd2, 0, 0);
        vectors++;
        if (rdata !== 16'h000A) begin
            miscompares++;
            $display("FAIL bad_sticky: got %h expected 000a", rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int v = 0; v < 3; v++) begin
            apply(1, 0, IO, 16'h0100 + 16'(v), 0);
            tick();
        end
        apply(0, 0, 0, 0, 1);
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h0100) begin
            miscompares++;
            $display("FAIL mid_head: got valid=%b data=%h expected valid=1 data=0100", tx_valid, tx_data);
        end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL mid_async: got valid=%b data=%h expected valid=0 data=0000", tx_valid, tx_data);
        end
        #1 rst = 1'b0;
        model_reset();
        apply(0, 1, IO + 16'd2, 0, 1);
        vectors++;
        if (rdata !== 16'h0002) begin
            miscompares++;
            $display("FAIL mid_stat: got %h expected 0002", rdata);
        end
        apply(0, 1, IO + 16'd4, 0, 1);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL mid_cyc: got %h expected 0000", rdata);
        end
        tick();
        apply(0, 1, 16'h0010, 0, 1);
        vectors++;
        if (rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL mid_ram: got %h expected beef", rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 16'($urandom_range(0, 2 * RAM_WORDS - 1));
                2:       a = IO + 16'($urandom_range(0, 1));
                3:       a = IO + 16'd2 + 16'($urandom_range(0, 1));
                4:       a = IO + 16'd4 + 16'($urandom_range(0, 1));
                default: a = 16'($urandom_range(16'h0200, 16'hFEFF));
            endcase
            apply($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), a,
                  16'($urandom), 1'($urandom_range(0, 1)));
            if (rdata_known()) begin
                vectors++;
                if (rdata !== exp_rdata()) begin
                    miscompares++;
                    $display("FAIL rand_rdata_%0d: addr=%h got %h expected %h", n, addr, rdata, exp_rdata());
                end
            end
            vectors++;
            if (tx_valid !== (m_q.size() > 0)) begin
                miscompares++;
                $display("FAIL rand_valid_%0d: got %b expected %b", n, tx_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                vectors++;
                if (tx_data !== m_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_txdata_%0d: got %h expected %h", n, tx_data, m_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_full_push_pop();
        test_cycle();
        test_badaddr();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
